// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bundle, shift kinds.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNot   = 4'd5,
    OpShl   = 4'd6,
    OpShr   = 4'd7,
    OpSra   = 4'd8,
    OpRol   = 4'd9,
    OpAdc   = 4'd10,
    OpCmp   = 4'd11,
    OpRes12 = 4'd12,
    OpRes13 = 4'd13,
    OpRes14 = 4'd14,
    OpRes15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  typedef enum logic [1:0] {
    ShShl = 2'd0,
    ShShr = 2'd1,
    ShSra = 2'd2,
    ShRol = 2'd3
  } shift_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OpShl) || (op == OpShr) || (op == OpSra) || (op == OpRol);
  endfunction

  // Only meaningful when is_shift(op) holds; other opcodes map to SHL harmlessly.
  function automatic shift_e op_to_shift(input logic [3:0] op);
    shift_e k;
    case (op)
      OpShr:   k = ShShr;
      OpSra:   k = ShSra;
      OpRol:   k = ShRol;
      default: k = ShShl;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// One-bit-per-step shifter/rotator. Holds the working value between steps and
// exposes the value after the next step plus the bit that step pushes out.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  shift_e           load_kind,
  input  logic             step,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  logic [WIDTH-1:0] work_q;
  shift_e           kind_q;

  // Value and ejected bit for one step of the latched operation.
  always_comb begin
    next_value = work_q;
    out_bit    = 1'b0;
    unique case (kind_q)
      ShShl: begin
        next_value = {work_q[WIDTH-2:0], 1'b0};
        out_bit    = work_q[WIDTH-1];
      end
      ShShr: begin
        next_value = {1'b0, work_q[WIDTH-1:1]};
        out_bit    = work_q[0];
      end
      ShSra: begin
        next_value = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        out_bit    = work_q[0];
      end
      ShRol: begin
        next_value = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        out_bit    = work_q[WIDTH-1];
      end
      default: begin
        next_value = work_q;
        out_bit    = 1'b0;
      end
    endcase
  end

  // Working register: load on accept, advance one bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      kind_q <= ShShl;
    end else if (load) begin
      work_q <= load_val;
      kind_q <= load_kind;
    end else if (step) begin
      work_q <= next_value;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides, a persistent flag
// register for ADC chaining and a bit-serial shift/rotate path.
// Optional build macro ALU_SAT_EN: ADD/ADC clamp to all-ones on carry-out and
// SUB clamps to zero on borrow; carry/ovf still report the unclamped condition.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = StIdle;
  localparam logic [1:0] EXEC = StExec;
  localparam logic [1:0] DONE = StDone;

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic [SHW-1:0]   n;
  logic             shift_op;
  logic             cin;
  logic [WIDTH:0]   sum, diff;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  logic             sh_load, sh_step, sh_out;
  logic [WIDTH-1:0] sh_next;

  assign n        = b[SHW-1:0];
  assign shift_op = is_shift(op);
  assign cin      = (op == OpAdc) ? flags_q.carry : 1'b0;
  assign sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff     = {1'b0, a} - {1'b0, b};
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Single-cycle result and flags; shifts here only cover the n == 0 case.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OpAdd, OpAdc: begin
        alu_res         = sum[WIDTH-1:0];
        alu_flags.carry = sum[WIDTH];
        alu_flags.ovf   = add_ovf;
`ifdef ALU_SAT_EN
        if (sum[WIDTH]) alu_res = '1;
`endif
      end
      OpSub: begin
        alu_res         = diff[WIDTH-1:0];
        alu_flags.carry = diff[WIDTH];
        alu_flags.ovf   = sub_ovf;
`ifdef ALU_SAT_EN
        if (diff[WIDTH]) alu_res = '0;
`endif
      end
      OpAnd: alu_res = a & b;
      OpOr:  alu_res = a | b;
      OpXor: alu_res = a ^ b;
      OpNot: alu_res = ~a;
      OpShl, OpShr, OpSra, OpRol: alu_res = a;
      OpCmp: begin
        alu_res         = a;
        alu_flags.carry = diff[WIDTH];
        alu_flags.ovf   = sub_ovf;
      end
      default: alu_res = '0;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[WIDTH-1];
    if (op == OpCmp) begin
      alu_flags.zero = (a == b);
      alu_flags.neg  = diff[WIDTH-1];
    end
  end

  alu_shift_unit #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_val  (a),
    .load_kind (op_to_shift(op)),
    .step      (sh_step),
    .next_value(sh_next),
    .out_bit   (sh_out)
  );

  // FSM next state, counter and result/flag write-back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (shift_op && (n != '0)) begin
            state_d = EXEC;
            cnt_d   = n;
            sh_load = 1'b1;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            flags_d  = alu_flags;
          end
        end
      end
      EXEC: begin
        sh_step = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d       = DONE;
          result_d      = sh_next;
          flags_d.carry = sh_out;
          flags_d.zero  = (sh_next == '0);
          flags_d.neg   = sh_next[WIDTH-1];
          flags_d.ovf   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed scenarios plus random ops
// against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry, zero, neg, ovf;

  int tests = 0;
  int fails = 0;
  int mcarry = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: results computed straight from the opcode definitions.
  task automatic model(input int o, input int x, input int y, output int r, output int c,
                       output int z, output int ng, output int ov, output int lat);
    int n, t, s;
    n = y & 7;
    c = 0; ov = 0; lat = 1; r = 0;
    case (o)
      0, 10: begin
        t  = x + y + ((o == 10) ? mcarry : 0);
        s  = sx(x) + sx(y) + ((o == 10) ? mcarry : 0);
        r  = t & 255;
        c  = (t > 255) ? 1 : 0;
        ov = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (c != 0) r = 255;
`endif
      end
      1, 11: begin
        t  = x - y;
        s  = sx(x) - sx(y);
        r  = (o == 11) ? x : (t & 255);
        c  = (x < y) ? 1 : 0;
        ov = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (o == 1 && c != 0) r = 0;
`endif
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (~x) & 255;
      6: begin
        r = (x << n) & 255;
        c = (n != 0) ? ((x >> (8 - n)) & 1) : 0;
      end
      7: begin
        r = x >> n;
        c = (n != 0) ? ((x >> (n - 1)) & 1) : 0;
      end
      8: begin
        r = (sx(x) >>> n) & 255;
        c = (n != 0) ? ((sx(x) >>> (n - 1)) & 1) : 0;
      end
      9: begin
        r = ((x << n) | (x >> (8 - n))) & 255;
        c = (n != 0) ? (r & 1) : 0;
      end
      default: r = 0;
    endcase
    if (o >= 6 && o <= 9 && n != 0) lat = n + 1;
    z  = (r == 0) ? 1 : 0;
    ng = (r >> 7) & 1;
    if (o == 11) begin
      z  = (x == y) ? 1 : 0;
      ng = (((x - y) & 255) >> 7) & 1;
    end
  endtask

  // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
  task automatic do_op(input int o, input int x, input int y, input int hold);
    int r, c, z, ng, ov, lat, cyc;
    model(o, x, y, r, c, z, ng, ov, lat);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    op = 4'(o);
    a  = 8'(x);
    b  = 8'(y);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk("busy_in_ready", in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency op%0d", o), cyc, lat);
    chk($sformatf("result op%0d a%0h b%0h", o, x, y), result, r);
    chk($sformatf("carry op%0d", o), carry, c);
    chk($sformatf("zero op%0d", o), zero, z);
    chk($sformatf("neg op%0d", o), neg, ng);
    chk($sformatf("ovf op%0d", o), ovf, ov);
    chk("done_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", result, r);
      chk("stall_flags", {carry, zero, neg, ovf}, {c[0], z[0], ng[0], ov[0]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    mcarry = c;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, neg, ovf}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    do_op(0, 200, 100, 0);
    do_op(1, 5, 5, 0);
    do_op(1, 3, 5, 0);
    do_op(11, 3, 5, 0);
    do_op(6, 8'h81, 3, 0);
    do_op(8, 8'h80, 7, 0);
    do_op(7, 8'h5a, 0, 0);
    do_op(0, 8'hff, 8'h01, 0);
    do_op(10, 0, 0, 0);
    do_op(9, 8'h96, 5, 0);
    do_op(0, 100, 100, 3);
    do_op(4, 8'h3c, 8'hff, 0);

    // Reset during a long shift: nothing partial may leak out.
    in_valid = 1'b1;
    op = 4'd6;
    a  = 8'hff;
    b  = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_flags", {carry, zero, neg, ovf}, 4'b0000);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mcarry = 0;
    @(negedge clk);
    do_op(0, 1, 1, 0);
    do_op(10, 8'h10, 8'h20, 0);

    // Random operations, with an occasional consumer stall.
    for (int i = 0; i < 60; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 3)) == 0 ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
